aes_spi_rx: RTL

AES_SPI_RX -- requirements
Module: aes_spi_rx

---
 rtl/aes_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 40 ++++
 rtl/aes_spi_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared command codes and receiver FSM state type for the AES SPI front end.
// No logic of its own: constants, the state enum and a width helper.
package aes_pkg;

    localparam logic [7:0] CMD_KEY  = 8'h4B;
    localparam logic [7:0] CMD_DATA = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_KEY,
        ST_DATA,
        ST_DISCARD
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// 2-flop synchronizer for one edge-detected input plus a bus of level-only inputs.
// Sync latency 2 clk, rise pulse 1 clk wide in the cycle after sync; no backpressure.
module spi_sync_edge #(
    parameter int               LVL_W   = 2,
    parameter logic [LVL_W-1:0] LVL_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_edge_async,
    input  logic [LVL_W-1:0] i_lvl_async,
    output logic             o_rise,
    output logic [LVL_W-1:0] o_lvl_sync
);

    logic             r_edge_meta;
    logic             r_edge_sync;
    logic             r_edge_prev;
    logic [LVL_W-1:0] r_lvl_meta;
    logic [LVL_W-1:0] r_lvl_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge_meta <= 1'b0;
            r_edge_sync <= 1'b0;
            r_edge_prev <= 1'b0;
            r_lvl_meta  <= LVL_RST;
            r_lvl_sync  <= LVL_RST;
        end else begin
            r_edge_meta <= i_edge_async;
            r_edge_sync <= r_edge_meta;
            r_edge_prev <= r_edge_sync;
            r_lvl_meta  <= i_lvl_async;
            r_lvl_sync  <= r_lvl_meta;
        end
    end

    assign o_rise     = r_edge_sync & ~r_edge_prev;
    assign o_lvl_sync = r_lvl_sync;

endmodule

// File: rtl/aes_spi_rx.sv
// SPI mode-0 slave receiving key/data frames for an AES core; blk_valid 1 clk after final bit pulse.
// blk_out is a single-entry valid/ready slot: a block finishing while the slot is full is dropped with overrun.
module aes_spi_rx #(
    parameter int NK     = 4,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic [NK*32-1:0]  key_out,
    output logic              key_valid,
    output logic [DATA_W-1:0] blk_out,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              overrun,
    output logic              cmd_err,
    output logic              busy
);
    import aes_pkg::*;

    localparam int KEY_W = NK * 32;
    localparam int PAY_W = max_int(KEY_W, DATA_W);
    localparam int STG_W = max_int(PAY_W, 8);
    localparam int CNT_W = $clog2(PAY_W) + 1;

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic             w_rise;
    logic [1:0]       w_lvl_sync;
    logic             w_cs_n;
    logic             w_mosi;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [STG_W-1:0] r_stage;
    logic [STG_W-1:0] w_stage_nxt;
    logic [1:0]       r_flush;
    logic             r_armed;

    logic [KEY_W-1:0]  r_key_out;
    logic              r_key_valid;
    logic [DATA_W-1:0] r_blk_out;
    logic              r_blk_valid;

    logic w_shift;
    logic w_cnt_clr;
    logic w_stage_clr;
    logic w_key_ld;
    logic w_blk_ld;
    logic w_overrun;
    logic w_cmd_err;

    spi_sync_edge #(
        .LVL_W   (2),
        .LVL_RST (2'b01)
    ) u_sync (
        .clk          (clk),
        .rst          (rst),
        .i_edge_async (sclk),
        .i_lvl_async  ({mosi, cs_n}),
        .o_rise       (w_rise),
        .o_lvl_sync   (w_lvl_sync)
    );

    assign w_cs_n      = w_lvl_sync[0];
    assign w_mosi      = w_lvl_sync[1];
    assign w_stage_nxt = {r_stage[STG_W-2:0], w_mosi};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_stage_clr = 1'b0;
        w_key_ld    = 1'b0;
        w_blk_ld    = 1'b0;
        w_overrun   = 1'b0;
        w_cmd_err   = 1'b0;
        // cs_n release wins over any coincident sclk edge
        if (r_state != ST_IDLE && w_cs_n) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
            w_stage_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_cs_n && r_armed) begin
                        w_state_nxt = ST_CMD;
                        w_cnt_clr   = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (w_rise) begin
                        w_shift = 1'b1;
                        if (r_cnt == CMD_LAST) begin
                            w_cnt_clr = 1'b1;
                            if (w_stage_nxt[7:0] == CMD_KEY) begin
                                w_state_nxt = ST_KEY;
                            end else if (w_stage_nxt[7:0] == CMD_DATA) begin
                                w_state_nxt = ST_DATA;
                            end else begin
                                w_state_nxt = ST_DISCARD;
                                w_cmd_err   = 1'b1;
                            end
                        end
                    end
                end
                ST_KEY: begin
                    if (w_rise) begin
                        w_shift = 1'b1;
                        if (r_cnt == KEY_LAST) begin
                            w_key_ld    = 1'b1;
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_rise) begin
                        w_shift = 1'b1;
                        if (r_cnt == DATA_LAST) begin
                            w_blk_ld    = !r_blk_valid || blk_ready;
                            w_overrun   = r_blk_valid && !blk_ready;
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                end
                ST_DISCARD: w_state_nxt = ST_DISCARD;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // The cs_n synchronizer resets to idle-high, so a pin held low through reset would
    // look like a fresh select; only arm once the chain has flushed and shows cs_n high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && w_cs_n) r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_stage <= '0;
        end else begin
            if (w_cnt_clr)    r_cnt <= '0;
            else if (w_shift) r_cnt <= r_cnt + 1'b1;
            if (w_stage_clr)  r_stage <= '0;
            else if (w_shift) r_stage <= w_stage_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
            r_blk_out   <= '0;
            r_blk_valid <= 1'b0;
        end else begin
            if (w_key_ld) begin
                r_key_out   <= w_stage_nxt[KEY_W-1:0];
                r_key_valid <= 1'b1;
            end
            if (w_blk_ld) begin
                r_blk_out   <= w_stage_nxt[DATA_W-1:0];
                r_blk_valid <= 1'b1;
            end else if (blk_ready) begin
                r_blk_valid <= 1'b0;
            end
        end
    end

    assign key_out   = r_key_out;
    assign key_valid = r_key_valid;
    assign blk_out   = r_blk_out;
    assign blk_valid = r_blk_valid;
    assign overrun   = w_overrun;
    assign cmd_err   = w_cmd_err;
    assign busy      = (r_state != ST_IDLE);

endmodule
